// File: rtl/mips_pkg.sv
// Types and constants shared by the multicycle MIPS datapath blocks.
package mips_pkg;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_HOLD   = 2'b11
    } pcsrc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } fetch_state_t;

    localparam int OP_MSB = 31;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select and PC write-enable for the fetch stage.
module pc_next_mux
    import mips_pkg::*;
(
    input  pcsrc_t      pcsrc,
    input  logic [31:0] pc,
    input  logic [25:0] jump_index,
    input  logic [31:0] aluresult,
    input  logic [31:0] aluout,
    input  logic        pcwrite,
    input  logic        branch,
    input  logic        zero,
    input  logic        stall,
    output logic [31:0] pc_next,
    output logic        pcen
);

    always_comb begin
        pc_next = pc;
        case (pcsrc)
            PC_ALU:    pc_next = aluresult;
            PC_ALUOUT: pc_next = aluout;
            PC_JUMP:   pc_next = {pc[31:28], jump_index, 2'b00};
            PC_HOLD:   pc_next = pc;
            default:   pc_next = pc;
        endcase
    end

    // A stalled decoder repeats its strobes, so the PC must not move until the access ends.
    assign pcen = (pcwrite | (branch & zero)) & ~stall;

endmodule

// File: rtl/mem_fetch_unit.sv
// PC, IR and MDR registers plus the unified-memory port with wait and timeout handling.
module mem_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        IorD,
    input  logic        IRwrite,
    input  logic        memwrite,
    input  logic        pcwrite,
    input  logic        branch,
    input  logic [1:0]  pcsrc,
    input  logic        zero,
    input  logic [31:0] aluresult,
    input  logic [31:0] aluout,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic [5:0]  op,
    output logic        stall,
    output logic        bus_error,
    output logic [1:0]  state_dbg
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    fetch_state_t state_q, state_d;
    logic [7:0]   wcnt_q, wcnt_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  mdr_q, mdr_d;
    logic         bus_error_q, bus_error_d;
    logic         acc;
    logic         complete;
    logic         pcen;
    logic [31:0]  pc_next;

    assign acc = IRwrite | IorD | memwrite;

    // Handshake: an access is offered while mem_req is high and finishes on the
    // first rising edge where mem_ready is also high; address, write enable and
    // write data stay stable from the first request cycle until that edge.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        bus_error_d = bus_error_q;
        mem_req     = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req = acc;
                if (acc && !mem_ready) begin
                    state_d = WAIT;
                    wcnt_d  = 8'd1;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = IDLE;
                    wcnt_d  = 8'd0;
                end else if (wcnt_q == TIMEOUT_CNT) begin
                    state_d     = ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            ERROR: mem_req = 1'b0;
            default: state_d = IDLE;
        endcase
    end

    assign stall    = (mem_req & ~mem_ready) | (state_q == ERROR);
    assign complete = mem_req & mem_ready;

    pc_next_mux u_pc_next_mux (
        .pcsrc      (pcsrc_t'(pcsrc)),
        .pc         (pc_q),
        .jump_index (instr_q[25:0]),
        .aluresult  (aluresult),
        .aluout     (aluout),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .zero       (zero),
        .stall      (stall),
        .pc_next    (pc_next),
        .pcen       (pcen)
    );

    always_comb begin
        pc_d    = pcen ? pc_next : pc_q;
        instr_d = instr_q;
        mdr_d   = mdr_q;
        // IRwrite takes priority so an IorD+IRwrite collision still loads IR.
        if (complete && IRwrite) begin
            instr_d = mem_rdata;
        end else if (complete && IorD && !memwrite) begin
            mdr_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wcnt_q      <= 8'd0;
            pc_q        <= RESET_PC;
            instr_q     <= 32'd0;
            mdr_q       <= 32'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            mdr_q       <= mdr_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign mem_addr  = IorD ? aluout : pc_q;
    assign mem_we    = memwrite;
    assign mem_wdata = wdata;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign mdr       = mdr_q;
    assign op        = instr_q[OP_MSB -: 6];
    assign bus_error = bus_error_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed bench for mem_fetch_unit: vector table for zero-wait operations plus wait, reset and timeout sequences.
module tb_mem_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk, reset;
    logic        IorD, IRwrite, memwrite, pcwrite, branch, zero, mem_ready;
    logic [1:0]  pcsrc;
    logic [31:0] aluresult, aluout, wdata, mem_rdata;
    logic [31:0] mem_addr, mem_wdata, pc, instr, mdr;
    logic        mem_req, mem_we, stall, bus_error;
    logic [5:0]  op;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    mem_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .IorD(IorD), .IRwrite(IRwrite), .memwrite(memwrite),
        .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .zero(zero),
        .aluresult(aluresult), .aluout(aluout), .wdata(wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .pc(pc), .instr(instr), .mdr(mdr), .op(op),
        .stall(stall), .bus_error(bus_error), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assert property (@(posedge clk) disable iff (reset) !(IRwrite && IorD))
        else $error("illegal IRwrite with IorD");

    typedef struct {
        logic        iord, irw, mw, pcw, br, z;
        logic [1:0]  src;
        logic [31:0] alures, aluo, wd, rd;
        logic        rdy;
        logic [31:0] e_addr;
        logic        e_req, e_we;
        logic [31:0] e_pc, e_instr, e_mdr;
    } vec_t;

    function automatic vec_t mk(logic iord, logic irw, logic mw, logic pcw, logic br, logic z,
                                logic [1:0] src, logic [31:0] alures, logic [31:0] aluo,
                                logic [31:0] wd, logic [31:0] rd, logic [31:0] e_addr,
                                logic e_req, logic e_we, logic [31:0] e_pc,
                                logic [31:0] e_instr, logic [31:0] e_mdr);
        vec_t v;
        v.iord = iord; v.irw = irw; v.mw = mw; v.pcw = pcw; v.br = br; v.z = z;
        v.src = src; v.alures = alures; v.aluo = aluo; v.wd = wd; v.rd = rd; v.rdy = 1'b1;
        v.e_addr = e_addr; v.e_req = e_req; v.e_we = e_we;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_mdr = e_mdr;
        return v;
    endfunction

    // scoreboard
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // drivers
    task automatic drive_idle();
        IorD = 0; IRwrite = 0; memwrite = 0; pcwrite = 0; branch = 0; zero = 0;
        pcsrc = 2'b00; aluresult = 32'd0; aluout = 32'd0; wdata = 32'd0;
        mem_rdata = 32'd0; mem_ready = 0;
    endtask

    task automatic apply(input vec_t v);
        IorD = v.iord; IRwrite = v.irw; memwrite = v.mw; pcwrite = v.pcw;
        branch = v.br; zero = v.z; pcsrc = v.src; aluresult = v.alures;
        aluout = v.aluo; wdata = v.wd; mem_rdata = v.rd; mem_ready = v.rdy;
    endtask

    vec_t vecs[9];
    int   stall_cnt;
    int   req_cnt;

    initial begin
        vecs[0] = mk(0,1,0,1,0,0,2'b00,32'h0040_0004,32'h0,32'h0,32'h8C22_0004,
                     32'h0040_0000,1,0,32'h0040_0004,32'h8C22_0004,32'h0);
        vecs[1] = mk(1,0,0,0,0,0,2'b00,32'h0,32'h1000_0008,32'h0,32'hDEAD_BEEF,
                     32'h1000_0008,1,0,32'h0040_0004,32'h8C22_0004,32'hDEAD_BEEF);
        vecs[2] = mk(1,0,1,0,0,0,2'b00,32'h0,32'h1000_0010,32'h1234_5678,32'hFFFF_FFFF,
                     32'h1000_0010,1,1,32'h0040_0004,32'h8C22_0004,32'hDEAD_BEEF);
        vecs[3] = mk(0,0,0,0,1,1,2'b01,32'h0,32'h0040_0020,32'h0,32'h5555_5555,
                     32'h0040_0004,0,0,32'h0040_0020,32'h8C22_0004,32'hDEAD_BEEF);
        vecs[4] = mk(0,0,0,0,1,0,2'b01,32'h0,32'h0040_0040,32'h0,32'h5555_5555,
                     32'h0040_0020,0,0,32'h0040_0020,32'h8C22_0004,32'hDEAD_BEEF);
        vecs[5] = mk(0,0,0,1,0,0,2'b11,32'h1111_1110,32'h2222_2220,32'h0,32'h5555_5555,
                     32'h0040_0020,0,0,32'h0040_0020,32'h8C22_0004,32'hDEAD_BEEF);
        vecs[6] = mk(0,1,0,1,0,0,2'b00,32'h0040_0004,32'h0,32'h0,32'h0800_0010,
                     32'h0040_0020,1,0,32'h0040_0004,32'h0800_0010,32'hDEAD_BEEF);
        vecs[7] = mk(0,0,0,1,0,0,2'b10,32'h0,32'h0,32'h0,32'h5555_5555,
                     32'h0040_0004,0,0,32'h0000_0040,32'h0800_0010,32'hDEAD_BEEF);
        vecs[8] = mk(0,0,0,0,1,1,2'b00,32'h0040_0200,32'h0,32'h0,32'h5555_5555,
                     32'h0000_0040,0,0,32'h0040_0200,32'h0800_0010,32'hDEAD_BEEF);

        drive_idle();
        reset = 1'b1;
        #2;
        check32("rst_pc", pc, RST_PC);
        check32("rst_instr", instr, 32'h0);
        check32("rst_mdr", mdr, 32'h0);
        check32("rst_op", {26'd0, op}, 32'h0);
        check1("rst_req", mem_req, 1'b0);
        check1("rst_stall", stall, 1'b0);
        check1("rst_buserr", bus_error, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // zero-wait table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check32($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
            check1($sformatf("v%0d_req", i), mem_req, vecs[i].e_req);
            check1($sformatf("v%0d_we", i), mem_we, vecs[i].e_we);
            check32($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wd);
            check1($sformatf("v%0d_stall", i), stall, 1'b0);
            @(posedge clk);
            #1;
            check32($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            check32($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
            check32($sformatf("v%0d_mdr", i), mdr, vecs[i].e_mdr);
            check32($sformatf("v%0d_op", i), {26'd0, op}, {26'd0, vecs[i].e_instr[31:26]});
        end

        // fetch with three wait cycles
        stall_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            IorD = 0; IRwrite = 1; memwrite = 0; pcwrite = 1; branch = 0;
            pcsrc = 2'b00; aluresult = 32'h0040_0204; mem_rdata = 32'hAABB_CCDD;
            mem_ready = (k == 3);
            #1;
            if (stall) stall_cnt++;
            check32($sformatf("wf%0d_addr", k), mem_addr, 32'h0040_0200);
            @(posedge clk);
            #1;
            check32($sformatf("wf%0d_pc", k), pc, (k == 3) ? 32'h0040_0204 : 32'h0040_0200);
            check32($sformatf("wf%0d_instr", k), instr, (k == 3) ? 32'hAABB_CCDD : 32'h0800_0010);
        end
        check32("wf_stall_cycles", stall_cnt, 32'd3);

        // reset during a pending load; a late ready must not capture
        @(negedge clk);
        drive_idle();
        IorD = 1; aluout = 32'h1000_0020; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check1("mid_stall", stall, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check32("mid_pc", pc, RST_PC);
        check32("mid_instr", instr, 32'h0);
        check32("mid_mdr", mdr, 32'h0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check32("mid_late_mdr", mdr, 32'h0);
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        #1;
        check32("mid_state", {30'd0, state_dbg}, {30'd0, IDLE});

        // timeout with mem_ready stuck low
        @(negedge clk);
        IorD = 1; aluout = 32'h1000_0030; mem_ready = 0;
        req_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!mem_req) break;
            req_cnt++;
            check1($sformatf("to%0d_buserr", c), bus_error, 1'b0);
            @(negedge clk);
        end
        check32("to_req_cycles", req_cnt, 32'd5);
        check1("to_buserr", bus_error, 1'b1);
        check1("to_req", mem_req, 1'b0);
        check1("to_stall", stall, 1'b1);
        check32("to_state", {30'd0, state_dbg}, {30'd0, ERROR});
        check32("to_pc", pc, RST_PC);
        @(negedge clk);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check1("to_sticky", bus_error, 1'b1);
        check1("to_sticky_stall", stall, 1'b1);
        @(negedge clk);
        drive_idle();
        #2;
        reset = 1'b1;
        #1;
        check1("to_rst_buserr", bus_error, 1'b0);
        check1("to_rst_stall", stall, 1'b0);
        check1("to_rst_req", mem_req, 1'b0);
        check32("to_rst_pc", pc, RST_PC);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check1("post_rst_buserr", bus_error, 1'b0);
        check32("post_rst_state", {30'd0, state_dbg}, {30'd0, IDLE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_fetch_unit.md
# mem_fetch_unit

Program-counter, instruction-register and memory-data-register stage of the multicycle MIPS core. It sits directly downstream of the main decoder FSM, consuming its `IorD`, `IRwrite`, `memwrite`, `branch`, `pcwrite` and `pcsrc` strobes, and directly upstream of it, feeding back the `op` field. It owns the single unified-memory port with a ready handshake and a timeout. It raises `stall` so the decoder holds its state while memory is busy.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `TIMEOUT`, default 16: maximum wait cycles per access before bus error; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `IorD` in 1: 0 selects PC as address (fetch); 1 selects `aluout` (data).
- `IRwrite` in 1: fetch strobe; load IR on access completion.
- `memwrite` in 1: store strobe; drive a write to `aluout`.
- `pcwrite` in 1: unconditional PC update.
- `branch` in 1: conditional PC update, qualified by `zero`.
- `pcsrc` in 2: next-PC select.
- `zero` in 1: ALU zero flag.
- `aluresult` in 32: combinational ALU result.
- `aluout` in 32: registered ALU output.
- `wdata` in 32: store data (B register).
- `mem_rdata` in 32: memory read data, valid when `mem_ready` is high.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_addr` out 32: memory address.
- `mem_req` out 1: access request.
- `mem_we` out 1: write enable, valid with `mem_req`.
- `mem_wdata` out 32: equals `wdata`.
- `pc` out 32: current PC.
- `instr` out 32: instruction register.
- `mdr` out 32: memory data register.
- `op` out 6: `instr[31:26]`.
- `stall` out 1: decoder must hold its state this cycle.
- `bus_error` out 1: sticky timeout flag.

## Operation
- Access needed: `acc = IRwrite | IorD | memwrite`.
- Address: `mem_addr = IorD ? aluout : pc`. `mem_we = memwrite`.
- Next PC by `pcsrc`:
  - 00: `aluresult`
  - 01: `aluout`
  - 10: `{pc[31:28], instr[25:0], 2'b00}`
  - 11: `pc` (hold)
- `pcen = (pcwrite | (branch & zero)) & ~stall`.
- FSM states: IDLE, WAIT, ERROR.
  - IDLE: `mem_req = acc`. If `acc & mem_ready`, the access completes at this edge and the FSM stays in IDLE. If `acc & ~mem_ready`, go to WAIT with `wcnt = 1`.
  - WAIT: `mem_req = 1`. On `mem_ready`, complete and go to IDLE. Otherwise, if `wcnt == TIMEOUT`, go to ERROR; else increment `wcnt`.
  - ERROR: `mem_req = 0`, `stall = 1`, `bus_error = 1`. The only exit is `reset`.
- `stall = (mem_req & ~mem_ready) | (state == ERROR)`.
- On completion:
  - Reads with `IRwrite=1` load `instr <= mem_rdata`.
  - Reads with `IRwrite=0, IorD=1, memwrite=0` load `mdr <= mem_rdata`.
  - Writes load neither register.
- `IRwrite & IorD` is illegal; `IorD` wins the address, and IR still loads. This is a verification assertion.
- Reset values: `pc = RESET_PC`, `instr = 0`, `mdr = 0`, `bus_error = 0`, state IDLE, `wcnt = 0`.
  - Resulting outputs: `mem_req = 0`, `stall = 0`, `op = 0`.
- Reset mid-access abandons the access with no register updates. A late `mem_ready` is ignored.

## Timing
- Zero-wait access: `mem_ready` high in the request cycle. Capture occurs at that edge, `stall` is never asserted, and latency is 1 cycle.
- N-wait access: `stall` is high for N cycles. Capture and PC update occur on the edge where `mem_ready` is sampled high.
- The PC updates on the same edge as the fetch completes: the fetch-state `pcwrite` is gated by `stall`.
- Timeout: with `mem_ready` held low, ERROR is entered after `TIMEOUT + 1` request cycles. `bus_error` rises the cycle after.
- `mem_addr`, `mem_we` and `mem_wdata` are combinational and must remain stable while `stall` is high; the held decoder guarantees this.

## Structure
- Shared package `mips_pkg`:
  - `pcsrc_t` enum: PC_ALU, PC_ALUOUT, PC_JUMP, PC_HOLD.
  - `fetch_state_t` enum: IDLE, WAIT, ERROR.
  - Constant `OP_MSB = 31`.
- One sub-module, `pc_next_mux`: combinational next-PC select plus `pcen` generation.
- Everything else stays flat: FSM, wait counter, PC, IR and MDR registers.

## Test plan
- Reset with `RESET_PC = 32'h0040_0000`, then a fetch (`IRwrite=1`, `pcwrite=1`, `pcsrc=00`, `aluresult=32'h0040_0004`) with `mem_ready=1` and `mem_rdata=32'h8C22_0004` -> `instr=32'h8C22_0004`, `op=6'b100011`, `pc=32'h0040_0004` after 1 edge, `stall` never high.
- Fetch with `mem_ready` low for 3 cycles -> `stall` high for exactly 3 cycles, `pc` unchanged until the 4th edge, then IR and PC update together.
- Load (`IorD=1`, `aluout=32'h1000_0008`, `mem_rdata=32'hDEAD_BEEF`) -> `mem_addr=32'h1000_0008`, `mdr=32'hDEAD_BEEF`, `instr` unchanged.
- Branch (`branch=1`, `pcsrc=01`, `aluout=32'h0040_0020`):
  - With `zero=1` -> `pc=32'h0040_0020`.
  - With `zero=0` -> `pc` unchanged.
- Jump with `pc=32'h0040_0004`, `instr=32'h0800_0010`, `pcsrc=10`, `pcwrite=1` -> `pc=32'h0000_0040`.
- `TIMEOUT=4` with `mem_ready` stuck low -> ERROR after 5 request cycles, then `bus_error=1`, `mem_req=0`, `stall=1`. Asserting `reset` mid-state clears all of them and restores `RESET_PC`.
